// File: rtl/cdc_fifo_read_ctrl.sv
// Read-side pointer/handshake controller for a dual-clock FIFO with a one-entry show-ahead output register.
// Optional sticky underflow flag is enabled by defining CDC_FIFO_RD_UNDERFLOW_EN.
module cdc_fifo_read_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH:0]   wptr_gray_sync,
  output logic [ADDR_WIDTH:0]   rptr_gray,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] wbin;
  logic          mem_nonempty;
  logic          pop;
  logic          load;

  assign wbin         = gray2bin(wptr_gray_sync);
  assign rbin_next    = rbin + {{(PW-1){1'b0}}, 1'b1};
  assign mem_nonempty = (rptr_gray != wptr_gray_sync);
  assign pop          = rd_valid && rd_ready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign load         = mem_nonempty && (!rd_valid || rd_ready);

  assign mem_raddr = rbin[ADDR_WIDTH-1:0];
  assign empty     = !rd_valid;
  assign level     = wbin - rbin;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rbin      <= '0;
      rptr_gray <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else if (load) begin
      rd_data   <= mem_rdata;
      rbin      <= rbin_next;
      rptr_gray <= bin2gray(rbin_next);
      rd_valid  <= 1'b1;
    end else if (pop) begin
      rd_valid  <= 1'b0;
    end
  end

`ifdef CDC_FIFO_RD_UNDERFLOW_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
    end else if (rd_ready && !rd_valid) begin
      underflow <= 1'b1;
    end
  end
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fifo_read_ctrl.sv
// Self-checking bench for cdc_fifo_read_ctrl: a queue-based FIFO model drives expectations
// for directed scenarios and a randomized read/write stream.
module tb_cdc_fifo_read_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] wptr_gray_sync;
  logic [4:0] rptr_gray;
  logic [3:0] mem_raddr;
  logic [7:0] mem_rdata;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       empty;
  logic [4:0] level;
  logic       underflow;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [16];
  logic [7:0] q [$];
  int         wcount;
  int         rcount;
  bit         m_valid;
  logic [7:0] m_data;
  bit         uf_seen;

  cdc_fifo_read_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clock(clock), .reset(reset), .wptr_gray_sync(wptr_gray_sync), .rptr_gray(rptr_gray),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .empty(empty), .level(level), .underflow(underflow)
  );

  always #5 clock = ~clock;

  always_comb mem_rdata = mem[mem_raddr];

  function automatic logic [4:0] to_gray(input int n);
    logic [4:0] b;
    b = n[4:0];
    return b ^ (b >> 1);
  endfunction

  function automatic bit exp_uf();
`ifdef CDC_FIFO_RD_UNDERFLOW_EN
    return uf_seen;
`else
    return 1'b0;
`endif
  endfunction

  task automatic push_word(input logic [7:0] d);
    mem[wcount % 16] = d;
    wcount++;
    wptr_gray_sync = to_gray(wcount);
    q.push_back(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rd_ready = 1'b0;
    wptr_gray_sync = '0;
    wcount = 0; rcount = 0; q.delete();
    m_valid = 0; m_data = '0; uf_seen = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // One clock edge: apply rd_ready, advance the model, then compare every output.
  task automatic step(input bit r);
    logic [4:0] g_before;
    bit old_valid;
    rd_ready = r;
    g_before = rptr_gray;
    old_valid = m_valid;
    if (q.size() > 0 && (!m_valid || r)) begin
      m_data = q.pop_front();
      m_valid = 1;
      rcount++;
    end else if (r) begin
      m_valid = 0;
    end
    if (r && !old_valid) uf_seen = 1;
    @(posedge clock);
    #1;
    checks++; if (rd_valid !== m_valid) begin errors++; $display("FAIL rd_valid: got %b want %b", rd_valid, m_valid); end
    checks++; if (empty !== !m_valid) begin errors++; $display("FAIL empty: got %b want %b", empty, !m_valid); end
    checks++; if (rd_data !== m_data) begin errors++; $display("FAIL rd_data: got %h want %h", rd_data, m_data); end
    checks++; if (rptr_gray !== to_gray(rcount)) begin errors++; $display("FAIL rptr_gray: got %h want %h", rptr_gray, to_gray(rcount)); end
    checks++; if (mem_raddr !== 4'(rcount % 16)) begin errors++; $display("FAIL mem_raddr: got %0d want %0d", mem_raddr, rcount % 16); end
    checks++; if (level !== 5'(q.size())) begin errors++; $display("FAIL level: got %0d want %0d", level, q.size()); end
    checks++; if (underflow !== exp_uf()) begin errors++; $display("FAIL underflow: got %b want %b", underflow, exp_uf()); end
    checks++; if ($countones(g_before ^ rptr_gray) > 1) begin errors++; $display("FAIL gray_onebit: got %h -> %h want at most one bit change", g_before, rptr_gray); end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0);
  endtask

  task automatic test_first_word();
    do_reset();
    push_word(8'hA5);
    step(1'b0);
    checks++; if (rd_data !== 8'hA5 || rptr_gray !== 5'h01) begin errors++; $display("FAIL first_word: got %h/%h want a5/01", rd_data, rptr_gray); end
    for (int i = 0; i < 5; i++) step(1'b0);
  endtask

  task automatic test_burst_four();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
    checks++; if (wptr_gray_sync !== 5'h06) begin errors++; $display("FAIL burst_wptr: got %h want 06", wptr_gray_sync); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem_raddr !== 4'(i)) begin errors++; $display("FAIL burst_raddr: got %0d want %0d", mem_raddr, i); end
      step(1'b1);
    end
    step(1'b1);
    checks++; if (empty !== 1'b1 || rptr_gray !== 5'h06) begin errors++; $display("FAIL burst_end: got empty=%b rptr=%h want 1/06", empty, rptr_gray); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      push_word(8'($urandom));
      step(1'b1);
      if (k == 16) begin
        checks++; if (rptr_gray !== 5'h18) begin errors++; $display("FAIL wrap16: got %h want 18", rptr_gray); end
      end
      if (k == 20) begin
        checks++; if (rptr_gray !== 5'h1E) begin errors++; $display("FAIL wrap20: got %h want 1e", rptr_gray); end
      end
    end
    step(1'b1);
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
    step(1'b0);
    #2 reset = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL async_valid: got valid=%b empty=%b want 0/1", rd_valid, empty); end
    checks++; if (rd_data !== 8'h00 || rptr_gray !== 5'h00 || mem_raddr !== 4'h0) begin errors++; $display("FAIL async_state: got %h/%h/%h want 00/00/0", rd_data, rptr_gray, mem_raddr); end
    checks++; if (level !== 5'd4 || underflow !== 1'b0) begin errors++; $display("FAIL async_level: got level=%0d uf=%b want 4/0", level, underflow); end
    do_reset();
    step(1'b0);
  endtask

  task automatic test_underflow();
    do_reset();
    step(1'b1);
    step(1'b0);
    push_word(8'h5A);
    step(1'b0);
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    do_reset();
    #1;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_reset: got %b want 0", underflow); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) != 0 && q.size() < 16) push_word(8'($urandom));
      step($urandom_range(0, 3) != 0 ? ((i / 100) % 2 == 0) || ($urandom_range(0, 1) == 1) : 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    rd_ready = 1'b0;
    wptr_gray_sync = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_first_word();
    test_burst_four();
    test_wrap();
    test_async_reset();
    test_underflow();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdc_fifo_read_ctrl.md
Name: cdc_fifo_read_ctrl

Overview:
Read-side pointer and handshake controller for the dual-clock FIFO. It runs entirely in the read clock domain and consumes the write pointer after the write-to-read synchronizer. It drives the memory read address and publishes the Gray-coded read pointer back to the read-to-write synchronizer. It presents data through a one-entry show-ahead output register with a valid/ready handshake.

Parameters:
ADDR_WIDTH, 4, memory address bits; FIFO memory depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, data word width

Ports:
clock  input  1  read-domain clock
reset  input  1  read-domain reset
wptr_gray_sync  input  ADDR_WIDTH+1  write pointer, Gray code, already synchronized into this domain
rptr_gray  output  ADDR_WIDTH+1  read pointer, Gray code, registered; feeds the read-to-write synchronizer
mem_raddr  output  ADDR_WIDTH  memory read address
mem_rdata  input  DATA_WIDTH  memory read data; combinational from mem_raddr
rd_data  output  DATA_WIDTH  output register data
rd_valid  output  1  rd_data holds a word
rd_ready  input  1  consumer accepts rd_data this cycle
empty  output  1  equal to !rd_valid
level  output  ADDR_WIDTH+1  words in memory not yet loaded: wbin - rbin mod 2**(ADDR_WIDTH+1)
underflow  output  1  sticky read-while-empty flag (see Optional Feature)

Behaviour:
- Reset: reset, asynchronous, active-high; clock clock. All flops clear: rbin=0, rptr_gray=0, rd_valid=0, rd_data=0, underflow=0. Outputs after reset: empty=1, mem_raddr=0, level=0 (for wptr_gray_sync=0).
- Internal state: binary read pointer rbin of ADDR_WIDTH+1 bits. rptr_gray is always registered as rbin ^ (rbin>>1). No combinational path from any input to rptr_gray.
- Write pointer decode: wbin = Gray-to-binary of wptr_gray_sync, computed combinationally (XOR prefix from MSB).
- mem_raddr = rbin[ADDR_WIDTH-1:0].
- mem_nonempty = (rptr_gray != wptr_gray_sync).
- pop = rd_valid && rd_ready. load = mem_nonempty && (!rd_valid || rd_ready).
- On a load:
  - rd_data <= mem_rdata
  - rbin <= rbin+1 and rptr_gray <= gray(rbin+1)
  - rd_valid <= 1
- On a pop without a load: rd_valid <= 0 and rd_data holds its value.
- Simultaneous pop and load give back-to-back transfer: rd_valid stays 1 and rd_data takes the next word. Sustained throughput is 1 word/cycle.
- Latency: if wptr_gray_sync changes from empty to non-empty at edge N, rd_valid is 1 after edge N+1.
- Backpressure: while rd_valid=1 and rd_ready=0, rd_data, rbin and rptr_gray hold.
- Wrap-around: rbin rolls over at 2**(ADDR_WIDTH+1). The MSB distinguishes laps, so full and empty are never confused. rptr_gray changes exactly one bit per increment, including at the wrap.
- Empty boundary: with mem_nonempty=0, no load occurs, rbin is frozen and mem_raddr is stable.
- rd_ready while rd_valid=0 is ignored by the datapath and does not advance any pointer.
- Reset mid-operation: all state returns to reset values immediately. The write side must be reset concurrently; this block does not flush the memory.

Optional Feature:
Macro CDC_FIFO_RD_UNDERFLOW_EN.
- Defined: underflow is a sticky flop. It sets on any cycle with rd_ready=1 and rd_valid=0, and clears only on reset.
- Undefined: underflow is tied to 0 and no flop is inferred.
- Datapath behaviour is identical in both builds.

Test Plan:
- Reset, then hold wptr_gray_sync=0 -> empty=1, rd_valid=0, rptr_gray=0, mem_raddr=0, level=0 for 10 cycles.
- Set wptr_gray_sync=5'h01 with mem_rdata=8'hA5 and rd_ready=0 -> rd_valid=1 one edge later, rd_data=8'hA5, rptr_gray=5'h01, level=0; rd_data stays stable for 5 cycles of rd_ready=0.
- Write pointer at 4 words (Gray 5'h06), rd_ready held at 1 -> four consecutive cycles of rd_valid=1, mem_raddr sequence 0,1,2,3, then empty=1 and rptr_gray=5'h06.
- Stream 20 words with rd_ready=1 (wrap) -> rptr_gray reaches 5'h18 after 16 loads, then 5'h1E after 20 loads. Every rptr_gray transition flips exactly one bit, and data order is preserved.
- Assert reset with 3 words pending and rd_valid=1 -> all outputs return to reset values in the same cycle, independent of clock.
- Built with CDC_FIFO_RD_UNDERFLOW_EN: pulse rd_ready=1 while empty -> underflow=1 and stays 1 until reset. Built without the macro: the same stimulus leaves underflow=0.
